// File: rtl/seq_mult_ctrl.sv
// rtl/seq_mult_ctrl.sv - shift-and-add multiplier sequencer
// Walks LOAD, then N ADD/SHIFT pairs, then a one-cycle DONE.
module seq_mult_ctrl #(
  parameter int N = 4,
  parameter int C = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  input  logic         q_lsb,
  output logic         load_regs,
  output logic         add_en,
  output logic         shift_en,
  output logic         busy,
  output logic         done,
  output logic [C-1:0] iter
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ADD   = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [C-1:0] ITER_LAST = C'(N - 1);

  state_t       state_q, state_d;
  logic [C-1:0] iter_q, iter_d;
  logic         load_q, add_q, shift_q, busy_q, done_q;

  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    case (state_q)
      IDLE: begin
        if (start && !abort) state_d = LOAD;
      end
      LOAD: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          state_d = ADD;
          iter_d  = '0;
        end
      end
      ADD: begin
        state_d = abort ? IDLE : SHIFT;
      end
      SHIFT: begin
        if (abort) begin
          state_d = IDLE;
        end else if (iter_q == ITER_LAST) begin
          state_d = DONE;
        end else begin
          state_d = ADD;
          iter_d  = iter_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output flops track the next state so they always mirror the state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      iter_q  <= '0;
      load_q  <= 1'b0;
      add_q   <= 1'b0;
      shift_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      load_q  <= (state_d == LOAD);
      add_q   <= (state_d == ADD);
      shift_q <= (state_d == SHIFT);
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == DONE);
    end
  end

  assign load_regs = load_q;
  assign add_en    = add_q & q_lsb;
  assign shift_en  = shift_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign iter      = iter_q;

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// tb/tb_seq_mult_ctrl.sv - scoreboard bench for seq_mult_ctrl
// Each queue entry holds one cycle of stimulus and the outputs expected in that cycle.
module tb_seq_mult_ctrl;
  localparam int N = 4;
  localparam int C = 2;

  localparam logic [4:0] F_IDLE  = 5'b00000;
  localparam logic [4:0] F_LOAD  = 5'b10010;
  localparam logic [4:0] F_SHIFT = 5'b00110;
  localparam logic [4:0] F_DONE  = 5'b00011;

  logic         clk = 1'b0;
  logic         rst, start, abort, q_lsb;
  logic         load_regs, add_en, shift_en, busy, done;
  logic [C-1:0] iter;

  typedef struct {
    logic         rs;
    logic         st;
    logic         ab;
    logic         q;
    logic [4:0]   fl;
    logic [C-1:0] it;
    string        tag;
  } step_t;

  step_t        sb_q[$];
  logic [C-1:0] m_iter;
  int           total = 0;
  int           bad   = 0;

  seq_mult_ctrl #(.N(N), .C(C)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .q_lsb(q_lsb),
    .load_regs(load_regs), .add_en(add_en), .shift_en(shift_en),
    .busy(busy), .done(done), .iter(iter)
  );

  always #5 clk = ~clk;

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic rs, input logic st, input logic ab, input logic q,
                      input logic [4:0] fl, input logic [C-1:0] it, input string tag);
    step_t e;
    e.rs = rs; e.st = st; e.ab = ab; e.q = q; e.fl = fl; e.it = it; e.tag = tag;
    sb_q.push_back(e);
  endtask

  task automatic push_idle(input int n, input logic st, input logic ab);
    for (int i = 0; i < n; i++) push(1'b1, st, ab, rb(), F_IDLE, m_iter, "idle");
  endtask

  // Expected trace of one operation; sb drives start while busy, abort_at/rst_at
  // name a step index (0 = LOAD, 1+2i = ADD i, 2+2i = SHIFT i), -1 for none.
  task automatic push_op(input logic [N-1:0] pat, input logic sb, input int abort_at,
                         input int rst_at, input logic ab_done);
    push(1'b1, 1'b1, 1'b0, rb(), F_IDLE, m_iter, "idle_start");
    if (rst_at == 0) begin
      push(1'b0, sb, 1'b0, 1'b1, F_IDLE, '0, "rst_load"); m_iter = '0; return;
    end
    push(1'b1, sb, abort_at == 0, rb(), F_LOAD, m_iter, "load");
    if (abort_at == 0) return;
    m_iter = '0;
    for (int i = 0; i < N; i++) begin
      if (rst_at == 1 + 2 * i) begin
        push(1'b0, sb, 1'b0, 1'b1, F_IDLE, '0, "rst_add"); m_iter = '0; return;
      end
      push(1'b1, sb, abort_at == 1 + 2 * i, pat[i], {1'b0, pat[i], 3'b010}, C'(i), "add");
      if (abort_at == 1 + 2 * i) return;
      if (rst_at == 2 + 2 * i) begin
        push(1'b0, sb, 1'b0, 1'b1, F_IDLE, '0, "rst_shift"); m_iter = '0; return;
      end
      push(1'b1, sb, abort_at == 2 + 2 * i, rb(), F_SHIFT, C'(i), "shift");
      if (abort_at == 2 + 2 * i) return;
      if (i < N - 1) m_iter = C'(i + 1);
    end
    push(1'b1, sb, ab_done, rb(), F_DONE, C'(N - 1), "done");
  endtask

  task automatic run();
    step_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      rst = e.rs; start = e.st; abort = e.ab; q_lsb = e.q;
      @(negedge clk);
      total++;
      assert ({load_regs, add_en, shift_en, busy, done} === e.fl) else begin
        bad++;
        $error("FAIL %s flags{load,add,shift,busy,done} got=%b exp=%b", e.tag,
               {load_regs, add_en, shift_en, busy, done}, e.fl);
      end
      total++;
      assert (iter === e.it) else begin
        bad++;
        $error("FAIL %s iter got=%0d exp=%0d", e.tag, iter, e.it);
      end
      total++;
      assert ($countones({load_regs, add_en, shift_en, done}) <= 1) else begin
        bad++;
        $error("FAIL %s exclusive got=%b exp=at_most_one", e.tag,
               {load_regs, add_en, shift_en, done});
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; abort = 1'b0; q_lsb = 1'b1;
    m_iter = '0;
    @(posedge clk);
    #1;
    // Reset state, with q_lsb high to show add_en stays low.
    push(1'b0, 1'b1, 1'b0, 1'b1, F_IDLE, '0, "reset");
    push(1'b0, 1'b0, 1'b0, 1'b1, F_IDLE, '0, "reset");
    push_idle(2, 1'b0, 1'b0);
    // Start pulse with multiplier bits 1,0,1,1.
    push_op(4'b1101, 1'b0, -1, -1, 1'b0);
    push_idle(2, 1'b0, 1'b0);
    // Abort in the second SHIFT leaves iter at 1.
    push_op(4'b0110, 1'b0, 4, -1, 1'b0);
    push_idle(2, 1'b0, 1'b0);
    // Reset in ADD at iter 2, idle without a fresh start, then a clean run.
    push_op(4'b1111, 1'b0, -1, 5, 1'b0);
    push_idle(3, 1'b0, 1'b0);
    push_op(4'b1010, 1'b0, -1, -1, 1'b0);
    push_idle(1, 1'b0, 1'b0);
    // start pulsing throughout a busy operation.
    push_op(4'b0011, 1'b1, -1, -1, 1'b0);
    push_idle(1, 1'b0, 1'b0);
    // start held high: back-to-back operations with one IDLE cycle between.
    push_op(4'b1001, 1'b1, -1, -1, 1'b0);
    push_op(4'b0101, 1'b1, -1, -1, 1'b0);
    push_op(4'b1110, 1'b1, -1, -1, 1'b0);
    push_idle(2, 1'b0, 1'b0);
    // start together with abort in IDLE, then abort during DONE.
    push_idle(3, 1'b1, 1'b1);
    push_op(4'b1001, 1'b0, -1, -1, 1'b1);
    push_idle(2, 1'b0, 1'b0);
    // Abort directly in LOAD and in the first ADD.
    push_op(4'b1111, 1'b0, 0, -1, 1'b0);
    push_idle(1, 1'b0, 1'b0);
    push_op(4'b1111, 1'b0, 1, -1, 1'b0);
    push_idle(2, 1'b0, 1'b0);
    run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
